mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 36 +++
 rtl/mem_arb_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Holds the FSM encoding, port-owner codes and bus opcode values.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StResp = 2'd2,
        StDone = 2'd3
    } arb_state_e;

    // Owner codes double as bit positions in the one-hot grant vector.
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic       BUS_RD     = 1'b0;
    localparam logic [3:0] WSTRB_NONE = 4'b0000;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_fields_t;

    // Fetches are always full-word reads with no byte enables.
    function automatic bus_fields_t fetch_fields(input logic [31:0] addr);
        bus_fields_t f;
        f.addr  = addr;
        f.wr    = BUS_RD;
        f.wstrb = WSTRB_NONE;
        f.wdata = '0;
        return f;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between the fetch and data ports.
// Produces a one-hot grant indexed by the owner codes.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_PRIO = 1
) (
    input  logic       inst_req,
    input  logic       data_req,
    input  logic       last_data,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (inst_req && data_req) begin
            // Round-robin hands the grant to whichever port was not served last.
            if ((DATA_PRIO != 0) || !last_data) begin
                grant[OWN_DATA] = 1'b1;
            end else begin
                grant[OWN_INST] = 1'b1;
            end
        end else if (data_req) begin
            grant[OWN_DATA] = 1'b1;
        end else if (inst_req) begin
            grant[OWN_INST] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) to single-bus arbiter with one outstanding transaction.
// IDLE latches the winner, ADDR presents the request, RESP waits for data, DONE pulses ok.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_PRIO = 1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ok,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,

    output logic        stall_F,
    output logic        stall_M
);

    arb_state_e  state_q;
    logic        owner_q;
    logic        last_data_q;
    bus_fields_t req_q;
    logic        bus_req_q;
    logic        inst_ok_q;
    logic        data_ok_q;
    logic [31:0] inst_rdata_q;
    logic [31:0] data_rdata_q;

    logic [1:0]  grant;
    bus_fields_t data_fields;

    assign data_fields = '{addr: data_addr, wr: data_wr, wstrb: data_wstrb, wdata: data_wdata};

    mem_arb_pick #(
        .DATA_PRIO (DATA_PRIO)
    ) u_pick (
        .inst_req  (inst_req),
        .data_req  (data_req),
        .last_data (last_data_q),
        .grant     (grant)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            owner_q      <= OWN_INST;
            last_data_q  <= OWN_DATA;
            req_q        <= '0;
            bus_req_q    <= 1'b0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            inst_ok_q <= 1'b0;
            data_ok_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant[OWN_DATA]) begin
                        owner_q     <= OWN_DATA;
                        last_data_q <= OWN_DATA;
                        req_q       <= data_fields;
                        bus_req_q   <= 1'b1;
                        state_q     <= StAddr;
                    end else if (grant[OWN_INST]) begin
                        owner_q     <= OWN_INST;
                        last_data_q <= OWN_INST;
                        req_q       <= fetch_fields(inst_addr);
                        bus_req_q   <= 1'b1;
                        state_q     <= StAddr;
                    end
                end
                StAddr: begin
                    if (bus_addr_ok) begin
                        bus_req_q <= 1'b0;
                        state_q   <= StResp;
                    end
                end
                StResp: begin
                    // Stores also complete here; their returned word still lands in rdata.
                    if (bus_data_ok) begin
                        if (owner_q == OWN_DATA) begin
                            data_rdata_q <= bus_rdata;
                            data_ok_q    <= 1'b1;
                        end else begin
                            inst_rdata_q <= bus_rdata;
                            inst_ok_q    <= 1'b1;
                        end
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_wr     = req_q.wr;
    assign bus_wstrb  = req_q.wstrb;
    assign bus_addr   = req_q.addr;
    assign bus_wdata  = req_q.wdata;

    assign inst_ok    = inst_ok_q;
    assign data_ok    = data_ok_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

    assign stall_F    = inst_req & ~inst_ok_q;
    assign stall_M    = data_req & ~data_ok_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: index 0 is round-robin, index 1 is data-priority.
// Both instances share all inputs; lone-request vectors are checked on both.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, data_req, data_wr;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    logic [31:0] inst_rdata_w [2];
    logic [31:0] data_rdata_w [2];
    logic [31:0] bus_addr_w   [2];
    logic [31:0] bus_wdata_w  [2];
    logic [3:0]  bus_wstrb_w  [2];
    logic        inst_ok_w    [2];
    logic        data_ok_w    [2];
    logic        bus_req_w    [2];
    logic        bus_wr_w     [2];
    logic        stall_f_w    [2];
    logic        stall_m_w    [2];

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_inst_rdata [2];
    logic [31:0] exp_data_rdata [2];

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_PRIO(0)) u_rr (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_rdata(inst_rdata_w[0]), .inst_ok(inst_ok_w[0]),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata_w[0]), .data_ok(data_ok_w[0]),
        .bus_req(bus_req_w[0]), .bus_wr(bus_wr_w[0]), .bus_wstrb(bus_wstrb_w[0]),
        .bus_addr(bus_addr_w[0]), .bus_wdata(bus_wdata_w[0]),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .stall_F(stall_f_w[0]), .stall_M(stall_m_w[0])
    );

    mem_arbiter #(.DATA_PRIO(1)) u_prio (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_rdata(inst_rdata_w[1]), .inst_ok(inst_ok_w[1]),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata_w[1]), .data_ok(data_ok_w[1]),
        .bus_req(bus_req_w[1]), .bus_wr(bus_wr_w[1]), .bus_wstrb(bus_wstrb_w[1]),
        .bus_addr(bus_addr_w[1]), .bus_wdata(bus_wdata_w[1]),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .stall_F(stall_f_w[1]), .stall_M(stall_m_w[1])
    );

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          addr_delay;
        int          data_delay;
        logic        noise;
        logic [3:0]  exp_wstrb;
    } vec_t;

    vec_t vecs [5];

    task automatic check32(input string name, input int k, input logic [31:0] act,
                           input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h", name, k, act, exp);
        end
    endtask

    task automatic check1(input string name, input int k, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %b, expected %b", name, k, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_wstrb  = 4'b0000;
        inst_addr   = '0;
        data_addr   = '0;
        data_wdata  = '0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_inst_rdata[k] = '0;
            exp_data_rdata[k] = '0;
        end
    endtask

    // From the ADDR state: immediate addr_ok then data_ok; returns in DONE.
    task automatic bus_cycle(input logic [31:0] rdata);
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = rdata;
        tick();
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0BAD_0BAD;
    endtask

    task automatic run_vec(input vec_t v);
        logic exp_wr;
        exp_wr = v.is_data & v.wr;
        clear_inputs();
        data_wr    = v.wr;
        data_wstrb = v.wstrb;
        if (v.is_data) begin
            data_req   = 1'b1;
            data_addr  = v.addr;
            data_wdata = v.wdata;
            inst_addr  = 32'hFFFF_0000;
        end else begin
            inst_req   = 1'b1;
            inst_addr  = v.addr;
            data_addr  = 32'h1234_5678;
            data_wdata = 32'h5555_AAAA;
        end
        tick();
        for (int a = 0; a <= v.addr_delay; a++) begin
            for (int k = 0; k < 2; k++) begin
                check1("addr_bus_req", k, bus_req_w[k], 1'b1);
                check32("addr_bus_addr", k, bus_addr_w[k], v.addr);
                check1("addr_bus_wr", k, bus_wr_w[k], exp_wr);
                check32("addr_bus_wstrb", k, 32'(bus_wstrb_w[k]), 32'(v.exp_wstrb));
                if (exp_wr) check32("addr_bus_wdata", k, bus_wdata_w[k], v.wdata);
                check1("addr_stall_F", k, stall_f_w[k], !v.is_data);
                check1("addr_stall_M", k, stall_m_w[k], v.is_data);
            end
            bus_addr_ok = (a == v.addr_delay);
            bus_data_ok = v.noise;
            tick();
        end
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        // Requester inputs wander while the transaction is in flight.
        inst_addr  = ~inst_addr;
        data_addr  = ~data_addr;
        data_wdata = ~data_wdata;
        data_wr    = ~data_wr;
        data_wstrb = ~data_wstrb;
        for (int k = 0; k < 2; k++) begin
            check1("resp_bus_req", k, bus_req_w[k], 1'b0);
            check1("resp_no_ok", k, inst_ok_w[k] | data_ok_w[k], 1'b0);
        end
        for (int d = 0; d < v.data_delay; d++) begin
            tick();
            for (int k = 0; k < 2; k++)
                check1("resp_wait_no_ok", k, inst_ok_w[k] | data_ok_w[k], 1'b0);
        end
        bus_data_ok = 1'b1;
        bus_rdata   = v.rdata;
        tick();
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0BAD_0BAD;
        for (int k = 0; k < 2; k++) begin
            if (v.is_data) exp_data_rdata[k] = v.rdata;
            else           exp_inst_rdata[k] = v.rdata;
            check1("done_inst_ok", k, inst_ok_w[k], !v.is_data);
            check1("done_data_ok", k, data_ok_w[k], v.is_data);
            check32("done_inst_rdata", k, inst_rdata_w[k], exp_inst_rdata[k]);
            check32("done_data_rdata", k, data_rdata_w[k], exp_data_rdata[k]);
            check32("done_bus_addr_stable", k, bus_addr_w[k], v.addr);
            check1("done_bus_wr_stable", k, bus_wr_w[k], exp_wr);
            check32("done_bus_wstrb_stable", k, 32'(bus_wstrb_w[k]), 32'(v.exp_wstrb));
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            check1("after_ok_cleared", k, inst_ok_w[k] | data_ok_w[k], 1'b0);
            check1("after_bus_req", k, bus_req_w[k], 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            is_d wr    wstrb    addr          wdata         rdata        ad dd nz   exp_wstrb
        vecs[0] = '{1'b0, 1'b0, 4'b0000, 32'h0000_0100, 32'h0,        32'h3C01_0001, 0, 0, 1'b0, 4'b0000};
        vecs[1] = '{1'b1, 1'b0, 4'b1111, 32'h0000_2000, 32'h0,        32'hDEAD_BEEF, 0, 0, 1'b0, 4'b1111};
        vecs[2] = '{1'b1, 1'b1, 4'b0011, 32'h0000_0010, 32'h0000_BEEF, 32'hA5A5_A5A5, 2, 0, 1'b1, 4'b0011};
        vecs[3] = '{1'b0, 1'b1, 4'b1111, 32'hBFC0_0000, 32'h0,        32'h8C08_0004, 0, 2, 1'b0, 4'b0000};
        vecs[4] = '{1'b1, 1'b1, 4'b1100, 32'h0000_7FFC, 32'h1234_0000, 32'h5A5A_0000, 1, 1, 1'b1, 4'b1100};

        // Reset values, checked before any clock edge.
        clear_inputs();
        resetn = 1'b0;
        #3;
        for (int k = 0; k < 2; k++) begin
            check1("rst_bus_req", k, bus_req_w[k], 1'b0);
            check1("rst_bus_wr", k, bus_wr_w[k], 1'b0);
            check32("rst_bus_wstrb", k, 32'(bus_wstrb_w[k]), 32'h0);
            check32("rst_bus_addr", k, bus_addr_w[k], 32'h0);
            check32("rst_bus_wdata", k, bus_wdata_w[k], 32'h0);
            check1("rst_ok", k, inst_ok_w[k] | data_ok_w[k], 1'b0);
            check32("rst_inst_rdata", k, inst_rdata_w[k], 32'h0);
            check32("rst_data_rdata", k, data_rdata_w[k], 32'h0);
        end
        tick();
        do_reset();
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Spurious handshakes in IDLE must not disturb anything.
        bus_data_ok = 1'b1;
        bus_addr_ok = 1'b1;
        bus_rdata   = 32'hFFFF_FFFF;
        tick();
        tick();
        bus_data_ok = 1'b0;
        bus_addr_ok = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check1("idle_spurious_ok", k, inst_ok_w[k] | data_ok_w[k], 1'b0);
            check1("idle_spurious_bus_req", k, bus_req_w[k], 1'b0);
            check32("idle_spurious_inst_rdata", k, inst_rdata_w[k], exp_inst_rdata[k]);
            check32("idle_spurious_data_rdata", k, data_rdata_w[k], exp_data_rdata[k]);
        end

        // Simultaneous fetch and load.
        do_reset();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0400;
        data_req  = 1'b1;
        data_addr = 32'h0000_0800;
        tick();
        check32("both_first_addr_prio", 1, bus_addr_w[1], 32'h0000_0800);
        check32("both_first_addr_rr", 0, bus_addr_w[0], 32'h0000_0400);
        bus_cycle(32'h1111_1111);
        check1("both_prio_data_ok_first", 1, data_ok_w[1], 1'b1);
        check1("both_prio_inst_ok_first", 1, inst_ok_w[1], 1'b0);
        check32("both_prio_data_rdata", 1, data_rdata_w[1], 32'h1111_1111);
        check1("both_prio_stall_F", 1, stall_f_w[1], 1'b1);
        data_req = 1'b0;
        tick();
        check1("no_regrant_in_done", 1, bus_req_w[1], 1'b0);
        tick();
        check1("second_bus_req", 1, bus_req_w[1], 1'b1);
        check32("second_addr_prio", 1, bus_addr_w[1], 32'h0000_0400);
        bus_cycle(32'h2222_2222);
        check1("second_inst_ok", 1, inst_ok_w[1], 1'b1);
        check1("second_data_ok", 1, data_ok_w[1], 1'b0);
        check32("second_inst_rdata", 1, inst_rdata_w[1], 32'h2222_2222);
        check32("second_data_rdata_held", 1, data_rdata_w[1], 32'h1111_1111);
        inst_req = 1'b0;
        tick();

        // Round-robin with both requests held for four transactions.
        do_reset();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0200;
        data_req  = 1'b1;
        data_addr = 32'h0000_0300;
        for (int i = 0; i < 4; i++) begin
            tick();
            check1("rr_bus_req", 0, bus_req_w[0], 1'b1);
            check32("rr_bus_addr", 0, bus_addr_w[0], (i % 2 == 0) ? 32'h200 : 32'h300);
            bus_cycle(32'hC0DE_0000 + 32'(i));
            check1("rr_inst_ok", 0, inst_ok_w[0], i % 2 == 0);
            check1("rr_data_ok", 0, data_ok_w[0], i % 2 == 1);
            check1("rr_stall_F", 0, stall_f_w[0], i % 2 == 1);
            check1("rr_stall_M", 0, stall_m_w[0], i % 2 == 0);
            tick();
        end
        clear_inputs();

        // Reset while in RESP, then a late bus response.
        do_reset();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0500;
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        check32("pre_reset_in_resp", 0, 32'(u_rr.state_q), 32'(StResp));
        resetn   = 1'b0;
        inst_req = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            check1("midrst_bus_req", k, bus_req_w[k], 1'b0);
            check32("midrst_bus_addr", k, bus_addr_w[k], 32'h0);
        end
        resetn = 1'b1;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hEEEE_EEEE;
        tick();
        bus_data_ok = 1'b0;
        for (int k = 0; k < 2; k++)
            check1("late_resp_no_ok", k, inst_ok_w[k] | data_ok_w[k], 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            check1("late_resp_no_ok2", k, inst_ok_w[k] | data_ok_w[k], 1'b0);
            check1("late_resp_bus_req", k, bus_req_w[k], 1'b0);
            check32("late_resp_inst_rdata", k, inst_rdata_w[k], 32'h0);
        end
        check32("late_resp_state_rr", 0, 32'(u_rr.state_q), 32'(StIdle));
        check32("late_resp_state_prio", 1, 32'(u_prio.state_q), 32'(StIdle));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
